// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   - instr_class_e : 2-bit instruction class
//   - CTRL_*        : sub-operations of the CTRL class (taken from aluctl)
//   - state_e       : sequencer FSM states
//   - field positions/widths of the 24-bit instruction word
//   - get_class()   : extract the class field from an instruction word
package seq_pkg;

  localparam int INSTR_W    = 24;
  localparam int PC_W       = 4;
  localparam int REG_W      = 4;
  localparam int IMM_W      = 8;
  localparam int ALU_W      = 2;
  localparam int CLASS_W    = 2;
  localparam int PROG_DEPTH = 16;

  // Field LSB positions inside the instruction word.
  localparam int CLASS_LSB  = 22;
  localparam int ALUCTL_LSB = 20;
  localparam int WA_LSB     = 16;
  localparam int RA1_LSB    = 12;
  localparam int RA2_LSB    = 8;
  localparam int IMM_LSB    = 0;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU_R = 2'b00,
    CLS_ALU_I = 2'b01,
    CLS_BEQZ  = 2'b10,
    CLS_CTRL  = 2'b11
  } instr_class_e;

  // CTRL sub-ops live in the aluctl field.
  localparam logic [ALU_W-1:0] CTRL_NOP  = 2'b00;
  localparam logic [ALU_W-1:0] CTRL_HALT = 2'b01;
  localparam logic [ALU_W-1:0] CTRL_JMP  = 2'b10;
  localparam logic [ALU_W-1:0] CTRL_RSVD = 2'b11;  // behaves as NOP

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_e;

  function automatic instr_class_e get_class(input logic [INSTR_W-1:0] instr);
    return instr_class_e'(instr[CLASS_LSB +: CLASS_W]);
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// prog_mem: 16 x 24-bit program store.
//   clk   : rising-edge clock
//   we    : write strobe (already qualified by the sequencer)
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
// Contents are never cleared by reset so a program survives a restart.
module prog_mem
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_reg [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer driving a downstream
// register-file/ALU block from a small program memory.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : run request (IDLE only)
//   prog_we/prog_addr/prog_data : program load port (IDLE, start=0 only)
//   Zero                      : ALU zero flag, used by BEQZ in its EXEC cycle
//   RA1, RA2, WA, immediate, ALUControl : fields of the instruction register
//   ALUSrc                    : 1 selects immediate as ALU B operand
//   write_enable              : register-file write strobe (EXEC, ALU classes)
//   busy                      : high outside IDLE
//   done                      : one-cycle pulse in the HALT state
//   pc                        : current program counter
// Each instruction takes two cycles: FETCH loads the instruction register,
// EXEC presents it to the datapath and updates pc.
module instr_sequencer
  import seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               Zero,
  output logic [REG_W-1:0]   RA1,
  output logic [REG_W-1:0]   RA2,
  output logic [REG_W-1:0]   WA,
  output logic [IMM_W-1:0]   immediate,
  output logic [ALU_W-1:0]   ALUControl,
  output logic               ALUSrc,
  output logic               write_enable,
  output logic               busy,
  output logic               done,
  output logic [PC_W-1:0]    pc
);

  state_e             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] ir_reg, ir_next;

  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    target;
  instr_class_e       ir_class;
  logic [ALU_W-1:0]   ir_aluctl;

  // Loads are only taken while idle and not starting, so a running program
  // can never be modified underneath itself.
  assign mem_we = prog_we && (state_reg == ST_IDLE) && !start && !rst;

  prog_mem u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_reg),
    .rdata (mem_rdata)
  );

  assign ir_class  = get_class(ir_reg);
  assign ir_aluctl = ir_reg[ALUCTL_LSB +: ALU_W];
  assign pc_inc    = pc_reg + 1'b1;            // natural 4-bit wrap 15 -> 0
  assign target    = ir_reg[IMM_LSB +: PC_W];  // branch/jump target is imm[3:0]

  // Datapath fields come straight from the instruction register in every state.
  assign WA         = ir_reg[WA_LSB  +: REG_W];
  assign RA1        = ir_reg[RA1_LSB +: REG_W];
  assign RA2        = ir_reg[RA2_LSB +: REG_W];
  assign immediate  = ir_reg[IMM_LSB +: IMM_W];
  assign ALUControl = ir_aluctl;
  assign ALUSrc     = (ir_class == CLS_ALU_I);

  assign busy = (state_reg != ST_IDLE);
  assign done = (state_reg == ST_HALT);
  assign pc   = pc_reg;

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    write_enable = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end

      ST_FETCH: begin
        ir_next    = mem_rdata;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        state_next = ST_FETCH;
        pc_next    = pc_inc;
        case (ir_class)
          CLS_ALU_R, CLS_ALU_I: begin
            write_enable = 1'b1;
          end
          CLS_BEQZ: begin
            // Zero here is the flag produced by this instruction's own operands.
            if (Zero) begin
              pc_next = target;
            end
          end
          CLS_CTRL: begin
            case (ir_aluctl)
              CTRL_HALT: begin
                pc_next    = pc_reg;
                state_next = ST_HALT;
              end
              CTRL_JMP: begin
                pc_next = target;
              end
              default: begin
                // CTRL_NOP and CTRL_RSVD just advance.
                pc_next = pc_inc;
              end
            endcase
          end
          default: begin
            pc_next = pc_inc;
          end
        endcase
      end

      ST_HALT: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: an instruction-level reference model is
// compared with every DUT output on every falling edge, and directed
// scenarios queue literal expectations that the same compare process checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, prog_we, Zero;
  logic [3:0]  prog_addr;
  logic [23:0] prog_data;
  logic [3:0]  RA1, RA2, WA, pc;
  logic [7:0]  immediate;
  logic [1:0]  ALUControl;
  logic        ALUSrc, write_enable, busy, done;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .Zero         (Zero),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .immediate    (immediate),
    .ALUControl   (ALUControl),
    .ALUSrc       (ALUSrc),
    .write_enable (write_enable),
    .busy         (busy),
    .done         (done),
    .pc           (pc)
  );

  localparam logic [23:0] NOP_W  = 24'hC0_0000;
  localparam logic [23:0] HALT_W = 24'hD0_0000;

  localparam int S_PC = 0, S_WA = 1, S_RA1 = 2, S_RA2 = 3, S_IMM = 4,
                 S_ALU = 5, S_SRC = 6, S_WE = 7, S_BUSY = 8, S_DONE = 9,
                 S_VAL = 10;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] act;
    logic [31:0] exp;
  } pin_t;

  pin_t pins[$];
  int   total = 0;
  int   bad   = 0;
  bit   model_on = 1'b0;

  // ---------------- reference model (instruction level) ----------------
  // m_phase: 0 idle, 1 fetch, 2 execute, 3 halted
  int          m_phase;
  logic [3:0]  m_pc;
  logic [23:0] m_ir;
  logic [23:0] m_mem [16];

  function automatic logic [3:0] next_pc(input logic [23:0] ir, input logic [3:0] cur,
                                         input logic z);
    logic [3:0] nxt;
    nxt = cur + 4'd1;
    if (ir[23:22] == 2'b10 && z) nxt = ir[3:0];
    if (ir[23:22] == 2'b11 && ir[21:20] == 2'b10) nxt = ir[3:0];
    if (ir[23:22] == 2'b11 && ir[21:20] == 2'b01) nxt = cur;
    return nxt;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_pc    <= 4'd0;
      m_ir    <= 24'd0;
    end else begin
      case (m_phase)
        0: begin
          if (prog_we && !start) m_mem[prog_addr] <= prog_data;
          if (start) begin
            m_phase <= 1;
            m_pc    <= 4'd0;
          end
        end
        1: begin
          m_ir    <= m_mem[m_pc];
          m_phase <= 2;
        end
        2: begin
          m_pc    <= next_pc(m_ir, m_pc, Zero);
          m_phase <= (m_ir[23:20] == 4'b1101) ? 3 : 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] actual(input int s, input logic [31:0] given);
    case (s)
      S_PC:    return 32'(pc);
      S_WA:    return 32'(WA);
      S_RA1:   return 32'(RA1);
      S_RA2:   return 32'(RA2);
      S_IMM:   return 32'(immediate);
      S_ALU:   return 32'(ALUControl);
      S_SRC:   return 32'(ALUSrc);
      S_WE:    return 32'(write_enable);
      S_BUSY:  return 32'(busy);
      S_DONE:  return 32'(done);
      default: return given;
    endcase
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      cmp("pc",           32'(pc),           32'(m_pc));
      cmp("WA",           32'(WA),           32'(m_ir[19:16]));
      cmp("RA1",          32'(RA1),          32'(m_ir[15:12]));
      cmp("RA2",          32'(RA2),          32'(m_ir[11:8]));
      cmp("immediate",    32'(immediate),    32'(m_ir[7:0]));
      cmp("ALUControl",   32'(ALUControl),   32'(m_ir[21:20]));
      cmp("ALUSrc",       32'(ALUSrc),       32'(m_ir[23:22] == 2'b01));
      cmp("write_enable", 32'(write_enable), 32'(m_phase == 2 && m_ir[23] == 1'b0));
      cmp("busy",         32'(busy),         32'(m_phase != 0));
      cmp("done",         32'(done),         32'(m_phase == 3));
    end
    while (pins.size() > 0) begin
      pin_t p;
      p = pins.pop_front();
      cmp(p.name, actual(p.sig, p.act), p.exp);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string n, input int s, input logic [31:0] e);
    pins.push_back('{n, s, 32'd0, e});
  endtask

  task automatic pin_val(input string n, input logic [31:0] a, input logic [31:0] e);
    pins.push_back('{n, S_VAL, a, e});
  endtask

  function automatic logic [23:0] mk(input logic [1:0] c, input logic [1:0] a,
                                     input logic [3:0] w, input logic [3:0] r1,
                                     input logic [3:0] r2, input logic [7:0] im);
    return {c, a, w, r1, r2, im};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) wr(4'(i), NOP_W);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Ticks until done is seen; n counts ticks taken. Expiry is a failure.
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (done !== 1'b1) pin("timeout_done", S_DONE, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 4'd0;
    prog_data = 24'd0; Zero = 1'b0;
    tick();
    model_on = 1'b1;

    // start together with reset must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    pin("rst_pc", S_PC, 0);   pin("rst_busy", S_BUSY, 0); pin("rst_done", S_DONE, 0);
    pin("rst_we", S_WE, 0);   pin("rst_WA", S_WA, 0);     pin("rst_RA1", S_RA1, 0);
    pin("rst_RA2", S_RA2, 0); pin("rst_imm", S_IMM, 0);   pin("rst_alu", S_ALU, 0);
    pin("rst_src", S_SRC, 0);
    tick();
    pin("start_in_rst_ignored", S_BUSY, 0);

    // ALU_I then HALT
    load_nops();
    wr(4'd0, mk(2'b01, 2'b10, 4'd2, 4'd0, 4'd0, 8'h0A));
    wr(4'd1, HALT_W);
    pulse_start();
    pin("alui_busy_fetch", S_BUSY, 1);
    tick();
    pin("alui_WA", S_WA, 2);  pin("alui_imm", S_IMM, 32'h0A); pin("alui_src", S_SRC, 1);
    pin("alui_alu", S_ALU, 2); pin("alui_we", S_WE, 1);
    wait_done(20, n);
    pin_val("alui_done_delay", 32'(n), 3);
    pin("alui_halt_pc", S_PC, 1);
    tick();
    pin("alui_busy_after", S_BUSY, 0);
    pin("alui_done_after", S_DONE, 0);

    // BEQZ at pc 3, taken and not taken
    load_nops();
    wr(4'd3, mk(2'b10, 2'b00, 4'd0, 4'd1, 4'd2, 8'h09));
    wr(4'd9, HALT_W);
    wr(4'd4, HALT_W);
    Zero = 1'b1;
    pulse_start();
    repeat (8) tick();
    pin("beqz_taken_pc", S_PC, 9);
    wait_done(40, n);
    pin("beqz_taken_halt_pc", S_PC, 9);
    tick();
    Zero = 1'b0;
    pulse_start();
    repeat (8) tick();
    pin("beqz_not_taken_pc", S_PC, 4);
    wait_done(40, n);
    pin("beqz_not_taken_halt_pc", S_PC, 4);
    tick();

    // JMP to 15, NOP at 15 wraps to 0; then reset in EXEC of ALU_R
    load_nops();
    wr(4'd0, mk(2'b00, 2'b11, 4'd7, 4'd1, 4'd2, 8'h00));
    wr(4'd1, mk(2'b11, 2'b10, 4'd0, 4'd0, 4'd0, 8'h0F));
    pulse_start();
    repeat (4) tick();
    pin("wrap_pc15", S_PC, 15);
    repeat (2) tick();
    pin("wrap_pc0", S_PC, 0);
    tick();
    pin("wrap_refetch_WA", S_WA, 7);
    pin("wrap_refetch_we", S_WE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pin("midrst_busy", S_BUSY, 0); pin("midrst_we", S_WE, 0); pin("midrst_pc", S_PC, 0);
    pin("midrst_done", S_DONE, 0); pin("midrst_WA", S_WA, 0);
    pulse_start();
    tick();
    pin("rerun_WA", S_WA, 7);
    pin("rerun_we", S_WE, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Dropped writes and start during EXEC
    load_nops();
    wr(4'd0, mk(2'b11, 2'b10, 4'd0, 4'd0, 4'd0, 8'h05));
    wr(4'd5, HALT_W);
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = mk(2'b01, 2'b00, 4'd3, 4'd0, 4'd0, 8'h33);
    start = 1'b1;
    tick();              // fetch of addr 0, write still asserted while busy
    start = 1'b0;
    tick();              // EXEC of JMP
    prog_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pin("start_in_exec_pc", S_PC, 5);
    tick();
    pin("dropped_write_alu", S_ALU, 1);
    pin("dropped_write_src", S_SRC, 0);
    pin("dropped_write_WA", S_WA, 0);
    tick();
    pin("dropped_write_done", S_DONE, 1);
    pin("dropped_write_pc", S_PC, 5);
    tick();

    // Sixteen NOP slots with HALT at 15
    load_nops();
    wr(4'd15, HALT_W);
    pulse_start();
    wait_done(60, n);
    pin_val("nop_run_cycles", 32'(n), 32);
    pin("nop_run_halt_pc", S_PC, 15);
    tick();

    // Randomized episodes
    for (int ep = 0; ep < 25; ep++) begin
      for (int i = 0; i < 16; i++) wr(4'(i), 24'($urandom));
      pulse_start();
      for (int c = 0; c < 60; c++) begin
        Zero      = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 7) == 0);
        prog_we   = ($urandom_range(0, 3) == 0);
        prog_addr = 4'($urandom_range(0, 15));
        prog_data = 24'($urandom);
        tick();
      end
      start   = 1'b0;
      prog_we = 1'b0;
      rst     = 1'b1;
      tick();
      rst = 1'b0;
      tick();
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
